// File: rtl/ce_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ce_gen_pkg
//  Description : Shared types, constants and helpers for the clock-enable
//                generator (ce_gen_multi / ce_gen_chan).
//  Revision    : 1.0  initial release
// ============================================================================
package ce_gen_pkg;

    // Default width of a channel rate field. Instances override their own
    // RATE_W parameter; this only sizes the convenience type below.
    localparam int DEF_RATE_W = 7;

    typedef logic [DEF_RATE_W-1:0] rate_t;

    // Stall policy encodings for a channel.
    localparam int STALL_DROP  = 0;   // tick during stall is lost
    localparam int STALL_DEFER = 1;   // one tick is owed until stall clears

    // Counter value at which the 180-degree pixel CE fires.
    function automatic int pix_half(input int div_log2);
        return (div_log2 < 1) ? 1 : (1 << (div_log2 - 1));
    endfunction

endpackage : ce_gen_pkg
`default_nettype wire

// File: rtl/ce_gen_chan.sv
`default_nettype none
// ============================================================================
//  Module      : ce_gen_chan
//  Description : One programmable-rate clock-enable channel. A counter runs
//                0..cur_rate; the wrap cycle is the "tick". The rate (or the
//                turbo rate) is latched only at the wrap, so a running period
//                always completes at the old rate and cnt never passes
//                cur_rate. A stall either drops the tick or defers it (one
//                owed pulse at most).
//  Ports       : clk, reset_n      clock, async active-low reset
//                rate              runtime rate (period = rate+1)
//                turbo             use TURBO_RATE for the next period
//                stall             suppress ce
//                ce                registered CE pulse
//                overrun           deferred tick merged into a pending one
//  Revision    : 1.0  initial release
// ============================================================================
module ce_gen_chan
    import ce_gen_pkg::*;
#(
    parameter int RATE_W     = 7,
    parameter int RESET_RATE = 111,
    parameter int TURBO_RATE = 2,
    parameter int STALL_MODE = STALL_DROP
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [RATE_W-1:0] rate,
    input  logic              turbo,
    input  logic              stall,
    output logic              ce,
    output logic              overrun
);

    localparam logic [RATE_W-1:0] c_reset_rate = RATE_W'(RESET_RATE);
    localparam logic [RATE_W-1:0] c_turbo_rate = RATE_W'(TURBO_RATE);

    logic [RATE_W-1:0] r_cnt;
    logic [RATE_W-1:0] r_cur_rate;
    logic              r_ce;
    logic              r_overrun;
    logic              w_tick;

    assign w_tick = (r_cnt == r_cur_rate);

    // Period counter; the next period's rate is sampled only on the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_cur_rate <= c_reset_rate;
        end else if (w_tick) begin
            r_cnt      <= '0;
            r_cur_rate <= turbo ? c_turbo_rate : rate;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
        end
    end

    if (STALL_MODE == STALL_DEFER) begin : g_defer
        logic r_pending;

        // A stalled tick becomes pending; a second stalled tick while one is
        // already owed is reported via overrun but still owes only one ce.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pending <= 1'b0;
                r_ce      <= 1'b0;
                r_overrun <= 1'b0;
            end else begin
                r_ce      <= (w_tick | r_pending) & ~stall;
                r_pending <= (w_tick | r_pending) & stall;
                r_overrun <= w_tick & r_pending & stall;
            end
        end
    end else begin : g_drop
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_ce      <= 1'b0;
                r_overrun <= 1'b0;
            end else begin
                r_ce      <= w_tick & ~stall;
                r_overrun <= 1'b0;
            end
        end
    end

    assign ce      = r_ce;
    assign overrun = r_overrun;

endmodule : ce_gen_chan
`default_nettype wire

// File: rtl/ce_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : ce_gen_multi
//  Description : Clock-enable generator. Holds a free-running pixel divider
//                producing two opposite-phase pixel CEs, plus NUM_CH
//                independent programmable-rate channels (ce_gen_chan).
//  Ports       : clk, reset_n        system clock, async active-low reset
//                rate[NUM_CH*RATE_W] packed rates, ch i at [i*RATE_W +: RATE_W]
//                turbo[NUM_CH]       per-channel turbo override
//                stall[NUM_CH]       per-channel CE suppression
//                ce_pix_p/ce_pix_n   pixel CE, phase 0 / phase 180
//                ce[NUM_CH]          channel CE pulses
//                overrun[NUM_CH]     deferred-tick overrun pulses
//  Revision    : 1.0  initial release
// ============================================================================
module ce_gen_multi
    import ce_gen_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int RATE_W       = 7,
    parameter int RESET_RATE   = 111,
    parameter int TURBO_RATE   = 2,
    parameter int STALL_DEFER  = 0,
    parameter int PIX_DIV_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*RATE_W-1:0] rate,
    input  logic [NUM_CH-1:0]        turbo,
    input  logic [NUM_CH-1:0]        stall,
    output logic                     ce_pix_p,
    output logic                     ce_pix_n,
    output logic [NUM_CH-1:0]        ce,
    output logic [NUM_CH-1:0]        overrun
);

    localparam logic [PIX_DIV_LOG2-1:0] c_pix_half =
        PIX_DIV_LOG2'(pix_half(PIX_DIV_LOG2));

    logic [PIX_DIV_LOG2-1:0] r_pix_cnt;
    logic                    r_ce_pix_p;
    logic                    r_ce_pix_n;

    // Pixel divider: wraps naturally at 2**PIX_DIV_LOG2; the two CEs are
    // half a period apart so they never coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_cnt  <= '0;
            r_ce_pix_p <= 1'b0;
            r_ce_pix_n <= 1'b0;
        end else begin
            r_pix_cnt  <= r_pix_cnt + 1'b1;
            r_ce_pix_p <= (r_pix_cnt == '0);
            r_ce_pix_n <= (r_pix_cnt == c_pix_half);
        end
    end

    assign ce_pix_p = r_ce_pix_p;
    assign ce_pix_n = r_ce_pix_n;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        ce_gen_chan #(
            .RATE_W     (RATE_W),
            .RESET_RATE (RESET_RATE),
            .TURBO_RATE (TURBO_RATE),
            .STALL_MODE (STALL_DEFER)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .rate    (rate[gi*RATE_W +: RATE_W]),
            .turbo   (turbo[gi]),
            .stall   (stall[gi]),
            .ce      (ce[gi]),
            .overrun (overrun[gi])
        );
    end

endmodule : ce_gen_multi
`default_nettype wire

// File: tb/tb_ce_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ce_gen_multi
//  Description : Scoreboard bench for ce_gen_multi. Three instances share one
//                clock/reset: the default configuration (rate change, turbo),
//                a rate-3 drop-policy channel and a rate-3 defer-policy
//                channel. Expected pulse cycles are queued per output; a
//                monitor pops and compares whenever an output pulses or a
//                pulse is due. Cycle 1 is the interval ending at the first
//                clock edge after reset release.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ce_gen_multi;

    localparam int NSIG = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic [13:0] m_rate;
    logic [1:0]  m_turbo, m_stall, m_ce, m_ov;
    logic        m_pp, m_pn;
    // Drop-policy instance
    logic [6:0]  d_rate;
    logic        d_turbo, d_stall, d_ce, d_ov, d_pp, d_pn;
    // Defer-policy instance
    logic [6:0]  f_rate;
    logic        f_turbo, f_stall, f_ce, f_ov, f_pp, f_pn;

    ce_gen_multi u_dut (
        .clk(clk), .reset_n(reset_n), .rate(m_rate), .turbo(m_turbo),
        .stall(m_stall), .ce_pix_p(m_pp), .ce_pix_n(m_pn), .ce(m_ce),
        .overrun(m_ov)
    );

    ce_gen_multi #(.NUM_CH(1), .RESET_RATE(3), .STALL_DEFER(0)) u_drop (
        .clk(clk), .reset_n(reset_n), .rate(d_rate), .turbo(d_turbo),
        .stall(d_stall), .ce_pix_p(d_pp), .ce_pix_n(d_pn), .ce(d_ce),
        .overrun(d_ov)
    );

    ce_gen_multi #(.NUM_CH(1), .RESET_RATE(3), .STALL_DEFER(1)) u_defer (
        .clk(clk), .reset_n(reset_n), .rate(f_rate), .turbo(f_turbo),
        .stall(f_stall), .ce_pix_p(f_pp), .ce_pix_n(f_pn), .ce(f_ce),
        .overrun(f_ov)
    );

    int unsigned cyc = 1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 1;
        else          cyc <= cyc + 1;
    end

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    int unsigned exp_q [NSIG][$];
    string names [NSIG] = '{"ce_pix_p", "ce_pix_n", "main_ce0", "main_ce1",
                            "main_ov0", "main_ov1", "drop_ce", "drop_ov",
                            "defer_ce", "defer_ov"};

    logic [NSIG-1:0] w_act;
    assign w_act = {f_ov, f_ce, d_ov, d_ce, m_ov[1], m_ov[0],
                    m_ce[1], m_ce[0], m_pn, m_pp};

    // Monitor: compares every pulse seen and every pulse due.
    bit e;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < NSIG; s++) begin
                e = (exp_q[s].size() > 0) && (exp_q[s][0] == cyc);
                if (e || w_act[s]) begin
                    checks++;
                    if (e != w_act[s]) begin
                        failures++;
                        $display("FAIL %s cycle=%0d actual=%0b expected=%0b",
                                 names[s], cyc, w_act[s], e);
                    end
                    if (e) void'(exp_q[s].pop_front());
                end
            end
        end
    end

    task automatic push_series(input int s, input int first, input int step,
                               input int last);
        for (int c = first; c <= last; c += step) exp_q[s].push_back(c);
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (w_act !== '0) begin
            failures++;
            $display("FAIL %s outputs=%b expected=%b", tag, w_act,
                     {NSIG{1'b0}});
        end
    endtask

    task automatic check_drained(input string tag);
        for (int s = 0; s < NSIG; s++) begin
            checks++;
            if (exp_q[s].size() != 0) begin
                failures++;
                $display("FAIL %s %s leftover=%0d expected=0", tag, names[s],
                         exp_q[s].size());
            end
            exp_q[s].delete();
        end
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        m_rate = {7'd20, 7'd111}; m_turbo = 2'b10; m_stall = 2'b00;
        d_rate = 7'd3; d_turbo = 1'b0; d_stall = 1'b0;
        f_rate = 7'd3; f_turbo = 1'b0; f_stall = 1'b0;

        // ---------------- Phase A ----------------
        push_series(0, 2, 16, 174);          // pixel phase 0
        push_series(1, 10, 16, 174);         // pixel phase 180
        push_series(2, 113, 14, 174);        // ch0: 111 then 13 from tick 112
        push_series(3, 113, 3, 131);         // ch1 turbo periods
        exp_q[3].push_back(152);             // ch1 rate 20 after turbo drop
        exp_q[3].push_back(173);
        push_series(6, 9, 4, 174);           // drop: ce at 5 lost
        exp_q[8].push_back(11);              // defer: owed pulse released
        exp_q[8].push_back(13);
        push_series(8, 21, 4, 169);          // tick+pending at 20 -> one ce
        exp_q[9].push_back(9);               // second stalled tick

        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk); #1 reset_n = 1'b1;
        mon_en = 1'b1;

        wait_cyc(4);   d_stall = 1'b1; f_stall = 1'b1;
        wait_cyc(6);   d_stall = 1'b0;
        wait_cyc(10);  f_stall = 1'b0;
        wait_cyc(16);  f_stall = 1'b1;
        wait_cyc(20);  f_stall = 1'b0;
        wait_cyc(50);  m_rate[6:0] = 7'd13;
        wait_cyc(128); m_turbo = 2'b00;
        wait_cyc(171); f_stall = 1'b1;       // tick 172 leaves a pending ce
        wait_cyc(174);

        // Asynchronous reset mid-period with a pending ce outstanding.
        #2 reset_n = 1'b0;
        mon_en = 1'b0;
        #1 check_zero("async_reset");
        check_drained("phaseA");

        // ---------------- Phase B ----------------
        repeat (3) @(posedge clk);
        f_stall = 1'b0;
        push_series(0, 2, 16, 131);
        push_series(1, 10, 16, 131);
        exp_q[2].push_back(113);             // reset rate, then rate 13
        exp_q[2].push_back(127);
        exp_q[3].push_back(113);             // next at 134
        push_series(6, 5, 4, 131);
        push_series(8, 5, 4, 131);           // pending was discarded
        @(negedge clk); #1 reset_n = 1'b1;
        mon_en = 1'b1;
        wait_cyc(131);
        @(posedge clk);
        mon_en = 1'b0;
        check_drained("phaseB");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ce_gen_multi
`default_nettype wire

// File: doc/ce_gen_multi.md
Name: ce_gen_multi

Overview:
- Parametrised clock-enable generator: successor to the top-level hand-coded pixel/CPU divider.
- Produces a phase-split pixel CE pair and NUM_CH independent programmable-rate CPU/peripheral CEs from one system clock.
- Each channel has a runtime rate, a turbo override (fast tape load), and a stall input (DDR not ready) with selectable drop/defer policy.
- Sits beside the PLL in emu; its outputs drive cpu6502 .ce, video_mixer .ce_pix and the tape logic.

Parameters:
- NUM_CH, 2, number of programmable CE channels (1..8)
- RATE_W, 7, width of each channel rate field
- RESET_RATE, 111, rate loaded into every channel at reset (period = rate+1 clocks)
- TURBO_RATE, 2, rate used while turbo[i]=1
- STALL_DEFER, 0, 0 = tick during stall is dropped; 1 = tick is held pending until stall clears
- PIX_DIV_LOG2, 4, pixel divider = 2**PIX_DIV_LOG2 (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rate  in  NUM_CH*RATE_W  packed per-channel rate, channel i at bits [i*RATE_W +: RATE_W]
- turbo  in  NUM_CH  per-channel turbo override
- stall  in  NUM_CH  per-channel CE suppression
- ce_pix_p  out  1  pixel CE, phase 0
- ce_pix_n  out  1  pixel CE, phase 180
- ce  out  NUM_CH  channel CE pulses
- overrun  out  NUM_CH  1-cycle pulse: deferred tick merged into an already pending one

Behaviour:
- All outputs are registered and 0 during reset. Internal state at reset: pix_cnt=0, cnt[i]=0, cur_rate[i]=RESET_RATE, pending[i]=0.
- Pixel divider: free-running PIX_DIV_LOG2-bit counter.
  - ce_pix_p <= (pix_cnt==0); ce_pix_n <= (pix_cnt==2**(PIX_DIV_LOG2-1)).
  - Each is 1 cycle wide, period 2**PIX_DIV_LOG2; they never coincide.
- Channel counter, every clk:
  - tick = (cnt==cur_rate).
  - If tick: cnt<=0 and cur_rate <= turbo[i] ? TURBO_RATE : rate[i].
  - Else cnt<=cnt+1.
  - Rate and turbo changes take effect only at a period boundary; the current period always completes at the old rate.
  - Rate 0 gives ce every cycle (if not stalled).
- Timing: with first post-reset edge = cycle 1, the first ce is seen in cycle RESET_RATE+2 (tick at cycle RESET_RATE+1, registered). Steady period = cur_rate+1.
- STALL_DEFER=0:
  - ce[i] <= tick & ~stall[i].
  - A stalled tick is lost; overrun stays 0.
- STALL_DEFER=1:
  - ce[i] <= (tick | pending[i]) & ~stall[i].
  - pending[i] <= (tick | pending[i]) & stall[i].
  - overrun[i] <= tick & pending[i] & stall[i]: one ce is owed, never two.
  - Tick and pending with stall=0: exactly one ce, pending clears, no overrun.
  - Stall deassert releases a pending ce on the next edge, independent of cnt.
- No counter overflow: cnt never exceeds cur_rate. If a new rate is below cnt, it is applied only after the wrap, so no reaching past 2**RATE_W.
- Async reset mid-period: everything returns to reset state at once. The first ce after release follows the timing rule above. Pending pulses are discarded.
- Channels are fully independent; no cross-channel phase relation is guaranteed.

Decomposition:
- ce_gen_pkg:
  - function for the pixel half-period constant
  - rate_t typedef sized by RATE_W (package parameter default 7)
  - STALL_DROP/STALL_DEFER localparams
- One sub-module, ce_gen_chan: counter, cur_rate, pending, ce and overrun for one channel.
- The top instantiates it NUM_CH times in a generate loop and holds the pixel divider.

Test Plan:
- Reset release, defaults, rate=111 both channels, no stall -> first ce[0] at cycle 113, then every 112 cycles; ce_pix_p at cycles 2,18,34…; ce_pix_n at 10,26,…
- Change rate[0] 111->13 at cycle 50 -> ce at 113, next at 127, then period 14; mid-period change does not shorten the running period.
- turbo[1]=1 from reset -> ce[1] at 113, then every 3 cycles; drop turbo -> one more 3-cycle period, then back to rate[1].
- STALL_DEFER=0, rate=3, stall high cycles 5..6 -> ce at cycle 5 missing, next ce at cycle 9, overrun never set.
- STALL_DEFER=1, rate=3, stall high cycles 4..10 -> no ce in 4..10; overrun pulse at the second stalled tick; exactly one ce at cycle 11.
- Assert reset_n=0 asynchronously mid-period with pending set -> all outputs 0 immediately; after release, timing is identical to the first scenario.
